muldiv_unit: RTL and testbench

Iterative multiply/divide unit implementing the full RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the pipelined CPU. It sits in the EX stage beside the ALU: the ID/EX register presents operands and funct3, and the unit runs a multi-cycle shift-add or restoring-division sequence while the CPU holds the pipeline on BUSY. It is parametrised in datapath width and in bits retired per cycle, so latency can be traded against area.

---
 rtl/muldiv_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Multiply uses a shift-add sequence on a 2*XLEN accumulator; divide uses
// restoring subtract-shift. BITS_PER_CYCLE steps are unrolled per CALC cycle.
module muldiv_unit #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2:0]      FUNCT3,
    input  logic [XLEN-1:0] OPERAND1,
    input  logic [XLEN-1:0] OPERAND2,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    localparam int unsigned N     = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned W2    = 2 * XLEN + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [XLEN-1:0]   op1_q, op1_d;
    logic [XLEN-1:0]   op2_q, op2_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [W2-1:0]     work_q, work_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic              special_q, special_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              is_div;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              div_zero;
    logic              div_ovf;
    logic              special;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_res;
    logic [W2-1:0]     step_w;

    // One shift-add step: low half holds the remaining multiplier bits,
    // high half (plus carry bit) accumulates the partial product.
    function automatic logic [W2-1:0] mul_step(input logic [W2-1:0] w,
                                               input logic [XLEN-1:0] m);
        logic [XLEN:0] sum;
        sum = w[2*XLEN:XLEN] + (w[0] ? {1'b0, m} : '0);
        return {1'b0, sum, w[XLEN-1:1]};
    endfunction

    // One restoring-division step: remainder in the upper XLEN+1 bits,
    // dividend shifting out / quotient shifting in at the bottom.
    function automatic logic [W2-1:0] div_step(input logic [W2-1:0] w,
                                               input logic [XLEN-1:0] d);
        logic [W2-1:0] sh;
        logic [XLEN:0] r;
        sh = w << 1;
        r  = sh[2*XLEN:XLEN];
        if (r >= {1'b0, d}) begin
            r     = r - {1'b0, d};
            sh[0] = 1'b1;
        end
        return {r, sh[XLEN-1:0]};
    endfunction

    // Operand decode: signedness per funct3, magnitudes and special divide cases.
    always_comb begin
        is_div   = funct3_q[2];
        sign_a   = ((funct3_q == 3'b001) || (funct3_q == 3'b010) ||
                    (funct3_q == 3'b100) || (funct3_q == 3'b110)) && op1_q[XLEN-1];
        sign_b   = ((funct3_q == 3'b001) || (funct3_q == 3'b100) ||
                    (funct3_q == 3'b110)) && op2_q[XLEN-1];
        mag_a    = sign_a ? (~op1_q + 1'b1) : op1_q;
        mag_b    = sign_b ? (~op2_q + 1'b1) : op2_q;
        div_zero = (op2_q == '0);
        div_ovf  = !funct3_q[0] && (op1_q == {1'b1, {(XLEN-1){1'b0}}}) && (op2_q == '1);
        special  = is_div && (div_zero || div_ovf);
    end

    // Final result: sign correction and half/quotient/remainder selection.
    always_comb begin
        prod = work_q[2*XLEN-1:0];
        if (neg_res_q) begin
            prod = ~prod + 1'b1;
        end
        quo = work_q[XLEN-1:0];
        if (neg_res_q) begin
            quo = ~quo + 1'b1;
        end
        rem = work_q[2*XLEN-1:XLEN];
        if (neg_rem_q) begin
            rem = ~rem + 1'b1;
        end
        if (special_q) begin
            if (div_zero) begin
                fix_res = funct3_q[1] ? op1_q : '1;
            end else begin
                fix_res = funct3_q[1] ? '0 : op1_q;
            end
        end else if (is_div) begin
            fix_res = funct3_q[1] ? rem : quo;
        end else if (funct3_q == 3'b000) begin
            fix_res = prod[XLEN-1:0];
        end else begin
            fix_res = prod[2*XLEN-1:XLEN];
        end
    end

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        opnd_d    = opnd_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        special_d = special_q;
        result_d  = result_q;
        done_d    = 1'b0;
        step_w    = work_q;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    funct3_d = FUNCT3;
                    op1_d    = OPERAND1;
                    op2_d    = OPERAND2;
                    state_d  = S_PREP;
                end
            end
            S_PREP: begin
                neg_res_d = sign_a ^ sign_b;
                neg_rem_d = sign_a;
                special_d = special;
                cnt_d     = '0;
                // Divide keeps the divisor, multiply keeps the multiplicand;
                // the other operand seeds the low half of the work register.
                opnd_d    = is_div ? mag_b : mag_a;
                work_d    = {{(XLEN+1){1'b0}}, (is_div ? mag_a : mag_b)};
                state_d   = special ? S_FIX : S_CALC;
            end
            S_CALC: begin
                for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
                    step_w = is_div ? div_step(step_w, opnd_q) : mul_step(step_w, opnd_q);
                end
                work_d = step_w;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = fix_res;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush wins over everything, including a pending start or the FIX write.
        if (FLUSH) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            funct3_q  <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            opnd_q    <= '0;
            work_q    <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            special_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            funct3_q  <= funct3_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            opnd_q    <= opnd_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            special_q <= special_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RESULT = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: three configurations (32/1, 32/4, 16/2) checked
// against an arithmetic reference model of the RV32M operations.
module tb_muldiv_unit;

    logic        CLK;
    logic        RESET;
    logic [2:0]  FUNCT3;
    logic [31:0] OP1;
    logic [31:0] OP2;
    logic        start0, start1, start2;
    logic        flush0;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [31:0] res0, res1;
    logic [15:0] res2;

    int tests_run;
    int tests_failed;
    logic [31:0] last0;

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut0 (
        .CLK(CLK), .RESET(RESET), .START(start0), .FUNCT3(FUNCT3),
        .OPERAND1(OP1), .OPERAND2(OP2), .FLUSH(flush0),
        .BUSY(busy0), .DONE(done0), .RESULT(res0)
    );

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut1 (
        .CLK(CLK), .RESET(RESET), .START(start1), .FUNCT3(FUNCT3),
        .OPERAND1(OP1), .OPERAND2(OP2), .FLUSH(1'b0),
        .BUSY(busy1), .DONE(done1), .RESULT(res1)
    );

    muldiv_unit #(.XLEN(16), .BITS_PER_CYCLE(2)) dut2 (
        .CLK(CLK), .RESET(RESET), .START(start2), .FUNCT3(FUNCT3),
        .OPERAND1(OP1[15:0]), .OPERAND2(OP2[15:0]), .FLUSH(1'b0),
        .BUSY(busy2), .DONE(done2), .RESULT(res2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
    endfunction

    function automatic logic [31:0] get_res(input int sel);
        return (sel == 0) ? res0 : (sel == 1) ? res1 : {16'h0, res2};
    endfunction

    function automatic int width_of(input int sel);
        return (sel == 2) ? 16 : 32;
    endfunction

    function automatic int iters_of(input int sel);
        return (sel == 0) ? 32 : 8;
    endfunction

    // Reference: RV32M semantics on w-bit operands using 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
        longint unsigned one  = 1;
        longint unsigned mask = (one << w) - 1;
        longint unsigned au   = longint'(a) & mask;
        longint unsigned bu   = longint'(b) & mask;
        longint          sa   = (((au >> (w - 1)) & 1) != 0) ? longint'(au) - longint'(one << w) : longint'(au);
        longint          sb   = (((bu >> (w - 1)) & 1) != 0) ? longint'(bu) - longint'(one << w) : longint'(bu);
        longint          minv = -longint'(one << (w - 1));
        longint          r;
        longint unsigned ru;
        case (f3)
            3'd0: r = longint'(au * bu);
            3'd1: r = (sa * sb) >>> w;
            3'd2: r = (sa * longint'(bu)) >>> w;
            3'd3: r = longint'((au * bu) >> w);
            3'd4: r = (bu == 0) ? -1 : ((sa == minv && sb == -1) ? sa : sa / sb);
            3'd5: r = (bu == 0) ? -1 : longint'(au / bu);
            3'd6: r = (bu == 0) ? sa : ((sa == minv && sb == -1) ? 0 : sa % sb);
            default: r = (bu == 0) ? longint'(au) : longint'(au % bu);
        endcase
        ru = longint'(r) & mask;
        return ru[31:0];
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b, input int w);
        logic [31:0] mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        logic [31:0] minv = 32'h1 << (w - 1);
        if (!f3[2]) return 1'b0;
        if ((b & mask) == 0) return 1'b1;
        return !f3[0] && ((a & mask) == minv) && ((b & mask) == mask);
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0: start0 = v;
            1: start1 = v;
            default: start2 = v;
        endcase
    endtask

    // Issue one operation and wait (bounded) for DONE; returns in the DONE cycle.
    task automatic do_op(input int sel, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res,
                         output int lat, output int busy_bad);
        FUNCT3 = f3;
        OP1    = a;
        OP2    = b;
        set_start(sel, 1'b1);
        @(posedge CLK); #1;
        set_start(sel, 1'b0);
        lat      = 0;
        busy_bad = 0;
        while (!get_done(sel) && lat < 200) begin
            if (get_busy(sel) !== 1'b1) busy_bad++;
            @(posedge CLK); #1;
            lat++;
        end
        if (get_done(sel) && get_busy(sel) !== 1'b0) busy_bad++;
        res = get_res(sel);
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        for (int s = 0; s < 3; s++) begin
            tests_run++;
            if (get_busy(s) !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_busy[%0d]: got %b expected 0", s, get_busy(s));
            end
            tests_run++;
            if (get_done(s) !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_done[%0d]: got %b expected 0", s, get_done(s));
            end
            tests_run++;
            if (get_res(s) !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_result[%0d]: got %h expected 0", s, get_res(s));
            end
        end
        RESET = 1'b0;
        @(posedge CLK); #1;
        last0 = 32'h0;
    endtask

    task automatic test_multiply;
        logic [2:0]  f3s [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
        logic [31:0] as  [4] = '{32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        logic [31:0] res;
        int lat, bb;
        for (int i = 0; i < 4; i++) begin
            do_op(0, f3s[i], as[i], bs[i], res, lat, bb);
            last0 = exp[i];
            tests_run++;
            if (res !== exp[i]) begin
                tests_failed++;
                $display("FAIL mul_result[%0d]: got %h expected %h", i, res, exp[i]);
            end
            tests_run++;
            if (lat !== 34 || bb !== 0) begin
                tests_failed++;
                $display("FAIL mul_timing[%0d]: got latency %0d busy errors %0d expected 34 and 0", i, lat, bb);
            end
            @(posedge CLK); #1;
            tests_run++;
            if (done0 !== 1'b0) begin
                tests_failed++;
                $display("FAIL done_pulse[%0d]: got %b expected 0", i, done0);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  f3s [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        logic [31:0] res;
        int lat, bb;
        for (int i = 0; i < 4; i++) begin
            do_op(0, f3s[i], as[i], bs[i], res, lat, bb);
            last0 = exp[i];
            tests_run++;
            if (res !== exp[i]) begin
                tests_failed++;
                $display("FAIL b2b_result[%0d]: got %h expected %h", i, res, exp[i]);
            end
            tests_run++;
            if (lat !== 34 || bb !== 0) begin
                tests_failed++;
                $display("FAIL b2b_timing[%0d]: got latency %0d busy errors %0d expected 34 and 0", i, lat, bb);
            end
        end
    endtask

    task automatic test_special;
        logic [2:0]  f3s [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        logic [31:0] res;
        int lat, bb;
        for (int i = 0; i < 4; i++) begin
            do_op(0, f3s[i], as[i], bs[i], res, lat, bb);
            last0 = exp[i];
            tests_run++;
            if (res !== exp[i]) begin
                tests_failed++;
                $display("FAIL special_result[%0d]: got %h expected %h", i, res, exp[i]);
            end
            tests_run++;
            if (lat !== 2 || bb !== 0) begin
                tests_failed++;
                $display("FAIL special_timing[%0d]: got latency %0d busy errors %0d expected 2 and 0", i, lat, bb);
            end
        end
    endtask

    task automatic test_random(input int sel, input int count);
        int          w = width_of(sel);
        logic [31:0] mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        logic [31:0] a, b, exp, res;
        logic [2:0]  f3;
        int lat, bb, exp_lat;
        for (int i = 0; i < count; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom & mask;
            b  = $urandom & mask;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: begin a = 32'h1 << (w - 1); b = mask; end
                2: begin a = a & 32'hFF; b = b & 32'hF; end
                default: ;
            endcase
            exp     = model(f3, a, b, w);
            exp_lat = is_special(f3, a, b, w) ? 2 : iters_of(sel) + 2;
            do_op(sel, f3, a, b, res, lat, bb);
            if (sel == 0) last0 = exp;
            tests_run++;
            if (res !== exp) begin
                tests_failed++;
                $display("FAIL random_result[%0d.%0d] f3=%0d a=%h b=%h: got %h expected %h", sel, i, f3, a, b, res, exp);
            end
            tests_run++;
            if (lat !== exp_lat || bb !== 0) begin
                tests_failed++;
                $display("FAIL random_timing[%0d.%0d]: got latency %0d busy errors %0d expected %0d and 0", sel, i, lat, bb, exp_lat);
            end
        end
    endtask

    task automatic test_flush;
        logic [31:0] res, exp;
        int lat, bb, stray;
        @(posedge CLK); #1;
        FUNCT3 = 3'd4; OP1 = 32'd1000; OP2 = 32'd3;
        start0 = 1'b1;
        @(posedge CLK); #1;
        start0 = 1'b0;
        repeat (9) begin
            @(posedge CLK); #1;
        end
        flush0 = 1'b1;
        @(posedge CLK); #1;
        flush0 = 1'b0;
        tests_run++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_calc_status: got busy %b done %b expected 0 0", busy0, done0);
        end
        tests_run++;
        if (res0 !== last0) begin
            tests_failed++;
            $display("FAIL flush_calc_result: got %h expected %h", res0, last0);
        end
        exp = model(3'd6, 32'hFFFF_FC18, 32'd7, 32);
        do_op(0, 3'd6, 32'hFFFF_FC18, 32'd7, res, lat, bb);
        last0 = exp;
        tests_run++;
        if (res !== exp || lat !== 34) begin
            tests_failed++;
            $display("FAIL flush_restart: got %h latency %0d expected %h latency 34", res, lat, exp);
        end

        @(posedge CLK); #1;
        FUNCT3 = 3'd0; OP1 = 32'd12; OP2 = 32'd12;
        start0 = 1'b1;
        @(posedge CLK); #1;
        start0 = 1'b0;
        repeat (33) begin
            @(posedge CLK); #1;
        end
        flush0 = 1'b1;
        @(posedge CLK); #1;
        flush0 = 1'b0;
        tests_run++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || res0 !== last0) begin
            tests_failed++;
            $display("FAIL flush_fix: got busy %b done %b result %h expected 0 0 %h", busy0, done0, res0, last0);
        end

        FUNCT3 = 3'd5; OP1 = 32'd9; OP2 = 32'd0;
        start0 = 1'b1;
        flush0 = 1'b1;
        @(posedge CLK); #1;
        start0 = 1'b0;
        flush0 = 1'b0;
        stray = 0;
        repeat (40) begin
            if (busy0 !== 1'b0 || done0 !== 1'b0) stray++;
            @(posedge CLK); #1;
        end
        tests_run++;
        if (stray !== 0 || res0 !== last0) begin
            tests_failed++;
            $display("FAIL flush_start: got %0d active cycles result %h expected 0 cycles result %h", stray, res0, last0);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] res, exp;
        int lat, bb;
        FUNCT3 = 3'd1; OP1 = 32'h1234_5678; OP2 = 32'h9ABC_DEF0;
        start0 = 1'b1;
        @(posedge CLK); #1;
        start0 = 1'b0;
        repeat (15) begin
            @(posedge CLK); #1;
        end
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        last0 = 32'h0;
        tests_run++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || res0 !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid: got busy %b done %b result %h expected 0 0 0", busy0, done0, res0);
        end
        exp = model(3'd3, 32'hDEAD_BEEF, 32'h0000_1001, 32);
        do_op(0, 3'd3, 32'hDEAD_BEEF, 32'h0000_1001, res, lat, bb);
        last0 = exp;
        tests_run++;
        if (res !== exp || lat !== 34) begin
            tests_failed++;
            $display("FAIL reset_mid_restart: got %h latency %0d expected %h latency 34", res, lat, exp);
        end
    endtask

    task automatic test_configs;
        logic [31:0] res;
        int lat, bb;
        do_op(1, 3'd5, 32'd100, 32'd7, res, lat, bb);
        tests_run++;
        if (res !== 32'd14 || lat !== 10 || bb !== 0) begin
            tests_failed++;
            $display("FAIL bpc4_divu: got %h latency %0d expected 0000000e latency 10", res, lat);
        end
        do_op(2, 3'd5, 32'd100, 32'd7, res, lat, bb);
        tests_run++;
        if (res !== 32'd14 || lat !== 10 || bb !== 0) begin
            tests_failed++;
            $display("FAIL x16_divu: got %h latency %0d expected 0000000e latency 10", res, lat);
        end
        do_op(2, 3'd0, 32'h00FF, 32'h0101, res, lat, bb);
        tests_run++;
        if (res !== 32'h0000_FFFF || lat !== 10 || bb !== 0) begin
            tests_failed++;
            $display("FAIL x16_mul: got %h latency %0d expected 0000ffff latency 10", res, lat);
        end
        test_random(1, 20);
        test_random(2, 20);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        RESET  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        flush0 = 1'b0;
        FUNCT3 = 3'd0;
        OP1    = 32'h0;
        OP2    = 32'h0;
        last0  = 32'h0;
        test_reset;
        test_multiply;
        test_back_to_back;
        test_special;
        test_random(0, 30);
        test_flush;
        test_reset_mid;
        test_configs;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
